lane_input_ctrl: RTL and testbench
==================================

// Module: lane_input_ctrl
// PURPOSE
//  Frame-synchronous controller for the four note lanes (left, down, up, right).
//  - Samples the keyboard keycode once per video frame and runs a per-lane press FSM.
//  - Drives the receptor press/flash highlight bits.
//  - Queues time-stamped hit events to the scoring unit.
//  - Arbitrates between lanes round-robin over a valid/ready handshake.
//  - Sits between the USB keycode register, the VGA receptor drawer and the judge/score logic.
// PARAMETERS
//  FLASH_FRAMES  4   frames lane_lit stays high after a press edge (1..15)
//  REARM_FRAMES  2   frames a lane ignores presses after release (0..15; 0 = no lockout)
//  STAMP_W       16  width of frame counter and hit time stamp
// PORTS
//  Clk         in   1        system clock
//  Reset_n     in   1        synchronous reset, active low
//  frame_tick  in   1        1-cycle pulse per frame (vsync edge); all lane updates occur on it
//  keycode     in   8        current USB keycode
//  lane_held   out  4        per-lane key held (receptor pressed colour)
//  lane_lit    out  4        per-lane flash highlight
//  hit_valid   out  1        hit event available
//  hit_ready   in   1        scoring unit accepts event
//  hit_lane    out  2        lane of event (0=L,1=D,2=U,3=R)
//  hit_frame   out  STAMP_W  frame stamp of the press
//  frame_count out  STAMP_W  free-running frame counter
//  overflow    out  1        sticky: a hit was dropped
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge): every output 0, all lane FSMs IDLE, all counters 0, pend bits 0,
//   round-robin pointer last_grant=3 (lane 0 has priority first).
//  Decode (combinational): 0x34->lane0, 0x33->lane1, 0x35->lane2, 0x3B->lane3, anything else = none.
//   Decode is used only on cycles with frame_tick=1.
//  frame_count: +1 on each tick; wraps 2^STAMP_W-1 -> 0. Stamp = frame_count value before the increment.
//  Lane FSM (transitions only on tick; m = lane matches decode):
//   IDLE  --m--> HELD, emits 1-cycle edge
//   HELD  --!m--> REARM with rcnt=REARM_FRAMES-1; if REARM_FRAMES=0, go to IDLE instead
//   REARM --rcnt==0--> IDLE (a press on this tick is ignored); else rcnt-1. m is ignored while in REARM.
//   lane_held[i] = (state==HELD), registered; it changes the cycle after the tick.
//  Flash: on edge, fcnt=FLASH_FRAMES; on any other tick, fcnt-1 if nonzero.
//   lane_lit[i] = (fcnt!=0). A re-press reloads fcnt.
//  Pend: on edge, pend[i]=1 and stamp[i] is captured.
//   If pend[i] is already 1 and is not being granted this cycle: drop the new event,
//    keep the old stamp, set overflow (cleared only by reset).
//   Grant and new edge on the same lane in the same cycle: the new edge wins; pend stays 1
//    with the new stamp; no overflow.
//  Arbiter: the output register is loadable when hit_valid=0 or (hit_valid & hit_ready).
//   When loadable and any pend bit (pre-update value) is set: select the first set lane scanning
//    last_grant+1, +2, ... mod 4; load hit_lane and hit_frame; clear that pend bit;
//    set hit_valid=1; update last_grant.
//   Back-to-back transfers: 1 per cycle. hit_lane and hit_frame are held stable while
//    hit_valid & !hit_ready.
//   If loadable and no pend bit is set: hit_valid -> 0.
//  Reset mid-transfer: event lost, hit_valid=0 on the next cycle; no partial state survives.
//  keycode changes between ticks have no effect.
// TESTING
//  1. Reset. keycode=0x34 for 3 ticks, then 0x00; REARM=2, FLASH=4, hit_ready=1.
//     -> lane_held=0001 for 3 frames; lane_lit=0001 for 4 frames;
//        one event: hit_lane=0, hit_frame=0.
//  2. Release lane1, then re-press on the 1st tick after release.
//     -> ignored; re-press on the 3rd tick -> new edge and event.
//  3. hit_ready=0; press lanes 3, 1, 2 on successive frames.
//     -> hit_valid=1 holding lane3 stable; on ready=1 the order is 3, then 1, then 2, back-to-back.
//  4. hit_ready=0; press lane2 twice (with REARM=0 between presses).
//     -> overflow=1; delivered stamp is the first press.
//  5. Preload frame_count=0xFFFF region (65535 ticks or force).
//     -> wrap to 0; stamp captured on the wrap tick = 0xFFFF.
//  6. Assert Reset_n=0 while hit_valid=1 and lane_lit!=0.
//     -> next cycle all outputs 0; overflow cleared.

Source files
------------

// File: rtl/lane_input_ctrl.sv
//==============================================================================
// Module : lane_input_ctrl
// Frame-synchronous four-lane press controller with round-robin hit queue.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module lane_input_ctrl #(
   parameter int FLASH_FRAMES = 4,
   parameter int REARM_FRAMES = 2,
   parameter int STAMP_W      = 16
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_tick,
   input  logic [7:0]         keycode,
   output logic [3:0]         lane_held,
   output logic [3:0]         lane_lit,
   output logic               hit_valid,
   input  logic               hit_ready,
   output logic [1:0]         hit_lane,
   output logic [STAMP_W-1:0] hit_frame,
   output logic [STAMP_W-1:0] frame_count,
   output logic               overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HELD  = 2'd1,
      S_REARM = 2'd2
   } lane_state_t;

   localparam logic [3:0] FLASH_LOAD = 4'(FLASH_FRAMES);
   localparam logic [3:0] REARM_LOAD = (REARM_FRAMES > 0) ? 4'(REARM_FRAMES - 1) : 4'd0;

   lane_state_t        state_q [4];
   lane_state_t        state_d [4];
   logic [3:0]         rcnt_q  [4];
   logic [3:0]         rcnt_d  [4];
   logic [3:0]         fcnt_q  [4];
   logic [3:0]         fcnt_d  [4];
   logic [STAMP_W-1:0] stamp_q [4];
   logic [STAMP_W-1:0] stamp_d [4];

   logic [3:0]         pend_q, pend_d;
   logic [1:0]         last_q, last_d;
   logic               ovf_q, ovf_d;
   logic [STAMP_W-1:0] fc_q, fc_d;
   logic               hv_q, hv_d;
   logic [1:0]         hl_q, hl_d;
   logic [STAMP_W-1:0] hf_q, hf_d;

   logic [3:0]         dec_w;
   logic [3:0]         edge_w;
   logic [3:0]         grant_w;

   always_comb begin
      dec_w = 4'b0000;
      case (keycode)
         8'h34:   dec_w = 4'b0001;
         8'h33:   dec_w = 4'b0010;
         8'h35:   dec_w = 4'b0100;
         8'h3B:   dec_w = 4'b1000;
         default: dec_w = 4'b0000;
      endcase
   end

   // Lane FSMs and flash counters only move on frame ticks.
   always_comb begin
      edge_w = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         rcnt_d[i]  = rcnt_q[i];
         fcnt_d[i]  = fcnt_q[i];
         if (frame_tick) begin
            case (state_q[i])
               S_IDLE: begin
                  if (dec_w[i]) begin
                     state_d[i] = S_HELD;
                     edge_w[i]  = 1'b1;
                  end
               end
               S_HELD: begin
                  if (!dec_w[i]) begin
                     state_d[i] = (REARM_FRAMES == 0) ? S_IDLE : S_REARM;
                     rcnt_d[i]  = REARM_LOAD;
                  end
               end
               S_REARM: begin
                  if (rcnt_q[i] == 4'd0) state_d[i] = S_IDLE;
                  else                   rcnt_d[i]  = rcnt_q[i] - 4'd1;
               end
               default: state_d[i] = S_IDLE;
            endcase
            if (edge_w[i])               fcnt_d[i] = FLASH_LOAD;
            else if (fcnt_q[i] != 4'd0)  fcnt_d[i] = fcnt_q[i] - 4'd1;
         end
      end
   end

   always_comb begin
      fc_d = frame_tick ? fc_q + STAMP_W'(1) : fc_q;
   end

   // Round-robin output stage; scan starts just after the last granted lane.
   always_comb begin
      logic       found;
      logic [1:0] sel;
      logic [1:0] idx;
      found   = 1'b0;
      sel     = last_q;
      idx     = last_q;
      grant_w = 4'b0000;
      hv_d    = hv_q;
      hl_d    = hl_q;
      hf_d    = hf_q;
      last_d  = last_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      if (!hv_q || hit_ready) begin
         if (found) begin
            grant_w[sel] = 1'b1;
            hv_d         = 1'b1;
            hl_d         = sel;
            hf_d         = stamp_q[sel];
            last_d       = sel;
         end else begin
            hv_d = 1'b0;
         end
      end
   end

   // A new edge overrides a same-cycle grant; otherwise a busy pend slot drops it.
   always_comb begin
      ovf_d = ovf_q;
      for (int i = 0; i < 4; i++) begin
         pend_d[i]  = pend_q[i] & ~grant_w[i];
         stamp_d[i] = stamp_q[i];
         if (edge_w[i]) begin
            if (pend_q[i] && !grant_w[i]) begin
               ovf_d = 1'b1;
            end else begin
               pend_d[i]  = 1'b1;
               stamp_d[i] = fc_q;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= S_IDLE;
            rcnt_q[i]  <= 4'd0;
            fcnt_q[i]  <= 4'd0;
            stamp_q[i] <= '0;
         end
         pend_q <= 4'b0000;
         last_q <= 2'd3;
         ovf_q  <= 1'b0;
         fc_q   <= '0;
         hv_q   <= 1'b0;
         hl_q   <= 2'd0;
         hf_q   <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            rcnt_q[i]  <= rcnt_d[i];
            fcnt_q[i]  <= fcnt_d[i];
            stamp_q[i] <= stamp_d[i];
         end
         pend_q <= pend_d;
         last_q <= last_d;
         ovf_q  <= ovf_d;
         fc_q   <= fc_d;
         hv_q   <= hv_d;
         hl_q   <= hl_d;
         hf_q   <= hf_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane_held[i] = (state_q[i] == S_HELD);
         lane_lit[i]  = (fcnt_q[i] != 4'd0);
      end
   end

   assign hit_valid   = hv_q;
   assign hit_lane    = hl_q;
   assign hit_frame   = hf_q;
   assign frame_count = fc_q;
   assign overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_input_ctrl.sv
//==============================================================================
// Module : tb_lane_input_ctrl
// Directed bench for lane_input_ctrl with hand-computed expectations.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_lane_input_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick;
   logic [7:0]  key;
   logic        ready;
   logic [3:0]  held, lit;
   logic        hv;
   logic [1:0]  hl;
   logic [15:0] hf, fc;
   logic        ovf;

   int vec  = 0;
   int errs = 0;

   lane_input_ctrl #(.FLASH_FRAMES(4), .REARM_FRAMES(2), .STAMP_W(16)) dut (
      .Clk         (clk),
      .Reset_n     (rst_n),
      .frame_tick  (tick),
      .keycode     (key),
      .lane_held   (held),
      .lane_lit    (lit),
      .hit_valid   (hv),
      .hit_ready   (ready),
      .hit_lane    (hl),
      .hit_frame   (hf),
      .frame_count (fc),
      .overflow    (ovf)
   );

   always #5 clk = ~clk;

   // One frame tick; returns on the falling edge after the tick edge.
   task automatic do_tick(input logic [7:0] k);
      @(negedge clk);
      key  = k;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick = 1'b0; key = 8'h00; ready = 1'b1;
      repeat (2) @(negedge clk);
      vec++; if ({held, lit} !== 8'h00) begin errs++; $display("FAIL reset_lanes: got %h want 00", {held, lit}); end
      vec++; if ({hv, hl, hf} !== 19'h0) begin errs++; $display("FAIL reset_hit: got %h want 0", {hv, hl, hf}); end
      vec++; if ({fc, ovf} !== 17'h0) begin errs++; $display("FAIL reset_fc_ovf: got %h want 0", {fc, ovf}); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_press_flash();
      do_tick(8'h34);
      vec++; if (held !== 4'b0001) begin errs++; $display("FAIL t1_held: got %b want 0001", held); end
      vec++; if (lit !== 4'b0001) begin errs++; $display("FAIL t1_lit: got %b want 0001", lit); end
      vec++; if (fc !== 16'd1) begin errs++; $display("FAIL t1_fc: got %0d want 1", fc); end
      vec++; if (hv !== 1'b0) begin errs++; $display("FAIL t1_latency: got %b want 0", hv); end
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd0, 16'd0}) begin errs++; $display("FAIL t1_event: got %h want %h", {hv, hl, hf}, {1'b1, 2'd0, 16'd0}); end
      cyc();
      vec++; if (hv !== 1'b0) begin errs++; $display("FAIL t1_drain: got %b want 0", hv); end
      do_tick(8'h34);
      do_tick(8'h34);
      vec++; if ({held, lit} !== 8'b0001_0001) begin errs++; $display("FAIL t1_held3: got %b want 00010001", {held, lit}); end
      do_tick(8'h00);
      vec++; if ({held, lit} !== 8'b0000_0001) begin errs++; $display("FAIL t1_flash4: got %b want 00000001", {held, lit}); end
      do_tick(8'h00);
      vec++; if (lit !== 4'b0000) begin errs++; $display("FAIL t1_flash_off: got %b want 0000", lit); end
      vec++; if (hv !== 1'b0) begin errs++; $display("FAIL t1_single_event: got %b want 0", hv); end
   endtask

   task automatic test_rearm();
      do_tick(8'h33);
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd1, 16'd5}) begin errs++; $display("FAIL t2_first: got %h want %h", {hv, hl, hf}, {1'b1, 2'd1, 16'd5}); end
      do_tick(8'h00);
      do_tick(8'h33);
      cyc();
      vec++; if ({held, hv} !== 5'b0000_0) begin errs++; $display("FAIL t2_ignore1: got %b want 00000", {held, hv}); end
      do_tick(8'h33);
      cyc();
      vec++; if ({held, hv} !== 5'b0000_0) begin errs++; $display("FAIL t2_ignore2: got %b want 00000", {held, hv}); end
      do_tick(8'h33);
      vec++; if (held !== 4'b0010) begin errs++; $display("FAIL t2_repress_held: got %b want 0010", held); end
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd1, 16'd9}) begin errs++; $display("FAIL t2_repress_event: got %h want %h", {hv, hl, hf}, {1'b1, 2'd1, 16'd9}); end
      do_tick(8'h00);
   endtask

   task automatic test_round_robin();
      do_tick(8'h00);
      do_tick(8'h00);
      ready = 1'b0;
      do_tick(8'h3B);
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd3, 16'd13}) begin errs++; $display("FAIL t3_lane3: got %h want %h", {hv, hl, hf}, {1'b1, 2'd3, 16'd13}); end
      do_tick(8'h33);
      do_tick(8'h35);
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd3, 16'd13}) begin errs++; $display("FAIL t3_stable: got %h want %h", {hv, hl, hf}, {1'b1, 2'd3, 16'd13}); end
      ready = 1'b1;
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd1, 16'd14}) begin errs++; $display("FAIL t3_second: got %h want %h", {hv, hl, hf}, {1'b1, 2'd1, 16'd14}); end
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd2, 16'd15}) begin errs++; $display("FAIL t3_third: got %h want %h", {hv, hl, hf}, {1'b1, 2'd2, 16'd15}); end
      cyc();
      vec++; if (hv !== 1'b0) begin errs++; $display("FAIL t3_empty: got %b want 0", hv); end
   endtask

   task automatic test_overflow();
      ready = 1'b0;
      do_tick(8'h00); do_tick(8'h00); do_tick(8'h00);
      do_tick(8'h35);
      cyc();
      vec++; if ({hv, hl, hf, ovf} !== {1'b1, 2'd2, 16'd19, 1'b0}) begin errs++; $display("FAIL t4_a: got %h want %h", {hv, hl, hf, ovf}, {1'b1, 2'd2, 16'd19, 1'b0}); end
      do_tick(8'h00); do_tick(8'h00); do_tick(8'h00);
      do_tick(8'h35);
      vec++; if (ovf !== 1'b0) begin errs++; $display("FAIL t4_b_noovf: got %b want 0", ovf); end
      do_tick(8'h00); do_tick(8'h00); do_tick(8'h00);
      do_tick(8'h35);
      vec++; if (ovf !== 1'b1) begin errs++; $display("FAIL t4_ovf: got %b want 1", ovf); end
      ready = 1'b1;
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd2, 16'd23}) begin errs++; $display("FAIL t4_kept_stamp: got %h want %h", {hv, hl, hf}, {1'b1, 2'd2, 16'd23}); end
      cyc();
      vec++; if ({hv, ovf} !== 2'b01) begin errs++; $display("FAIL t4_sticky: got %b want 01", {hv, ovf}); end
      do_tick(8'h00);
   endtask

   task automatic test_wrap();
      @(negedge clk);
      key  = 8'h00;
      tick = 1'b1;
      repeat (65535 - 29) @(negedge clk);
      tick = 1'b0;
      vec++; if (fc !== 16'hFFFF) begin errs++; $display("FAIL t5_pre: got %h want ffff", fc); end
      do_tick(8'h34);
      vec++; if (fc !== 16'h0000) begin errs++; $display("FAIL t5_wrap: got %h want 0000", fc); end
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd0, 16'hFFFF}) begin errs++; $display("FAIL t5_stamp: got %h want %h", {hv, hl, hf}, {1'b1, 2'd0, 16'hFFFF}); end
      do_tick(8'h00);
   endtask

   task automatic test_reset_mid();
      ready = 1'b0;
      do_tick(8'h33);
      cyc();
      vec++; if ({hv, lit, ovf} !== {1'b1, 4'b0011, 1'b1}) begin errs++; $display("FAIL t6_pre: got %b want 1_0011_1", {hv, lit, ovf}); end
      rst_n = 1'b0;
      cyc();
      vec++; if ({held, lit, hv, hl, hf, fc, ovf} !== 44'h0) begin errs++; $display("FAIL t6_cleared: got %h want 0", {held, lit, hv, hl, hf, fc, ovf}); end
      rst_n = 1'b1;
      cyc();
      vec++; if (hv !== 1'b0) begin errs++; $display("FAIL t6_no_leftover: got %b want 0", hv); end
      do_tick(8'h34);
      vec++; if ({held, fc} !== {4'b0001, 16'd1}) begin errs++; $display("FAIL t6_restart: got %h want %h", {held, fc}, {4'b0001, 16'd1}); end
      cyc();
      vec++; if ({hv, hl, hf} !== {1'b1, 2'd0, 16'd0}) begin errs++; $display("FAIL t6_event: got %h want %h", {hv, hl, hf}, {1'b1, 2'd0, 16'd0}); end
   endtask

   initial begin
      test_reset();
      test_press_flash();
      test_rearm();
      test_round_robin();
      test_overflow();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

`default_nettype wire
